// File: rtl/nanorv32_prog_loader_if.sv
// Byte-stream input and TCM0 word-write port of the boot loader.
// master = byte source / RAM side, slave = loader side.
interface nanorv32_prog_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nanorv32_prog_loader.sv
// Streaming boot loader: length-prefixed byte image -> little-endian TCM words, CPU held in reset until done.
// Optional trailing modulo-256 checksum byte when NANORV32_LOADER_CHECKSUM_EN is defined.

// One byte lane of the word assembler; dout forwards the byte being accepted this cycle.
module nanorv32_prog_loader_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] byte_q, byte_d;

  always_comb begin
    byte_d = byte_q;
    if (clr)       byte_d = '0;
    else if (load) byte_d = din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) byte_q <= '0;
    else        byte_q <= byte_d;
  end

  assign dout = load ? din : byte_q;
endmodule

module nanorv32_prog_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int BASE_WORD  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nanorv32_prog_loader_if.slave        bus,
  output logic                         cpu_rst_n,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);
  localparam int NUM_LANES = 4;
  localparam logic [32:0]           CAP  = 33'(1) << (ADDR_WIDTH + 2);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_WORD);

`ifdef NANORV32_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_FLUSH, S_CHK, S_DONE, S_ERROR} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERROR} state_e;
`endif

  state_e                state_q, state_d;
  logic [23:0]           len_q, len_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           rem_q, rem_d;
  logic [1:0]            lane_q, lane_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef NANORV32_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic                        accept, data_acc, emit;
  logic [31:0]                 len_full;
  logic [NUM_LANES-1:0][7:0]   lane_byte;

  assign accept   = bus.in_valid && in_ready_q;
  assign data_acc = accept && (state_q == S_DATA);
  // A word is emitted on its top lane or on the last payload byte; higher lanes are still clear then.
  assign emit     = data_acc && ((lane_q == 2'd3) || (rem_q == 32'd1));
  assign len_full = {bus.in_data, len_q};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    nanorv32_prog_loader_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (data_acc && (lane_q == 2'(i))),
      .clr  (emit),
      .din  (bus.in_data),
      .dout (lane_byte[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    lane_d      = lane_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_we_q ? mem_addr_q + ADDR_WIDTH'(1) : mem_addr_q;
`ifdef NANORV32_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_LEN;
        cnt_d   = 2'd0;
`ifdef NANORV32_LOADER_CHECKSUM_EN
        sum_d   = 8'd0;
`endif
      end
      S_LEN: if (accept) begin
        len_d = len_full[31:8];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (len_full == 32'd0) begin
`ifdef NANORV32_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_full} > CAP) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
            rem_d   = len_full;
            lane_d  = 2'd0;
          end
        end
      end
      S_DATA: if (accept) begin
        rem_d  = rem_q - 32'd1;
        lane_d = lane_q + 2'd1;
`ifdef NANORV32_LOADER_CHECKSUM_EN
        sum_d  = sum_q + bus.in_data;
`endif
        if (emit) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = lane_byte;
        end
        if (rem_q == 32'd1) state_d = S_FLUSH;
      end
      S_FLUSH: begin
`ifdef NANORV32_LOADER_CHECKSUM_EN
        state_d = S_CHK;
`else
        state_d = S_DONE;
`endif
      end
`ifdef NANORV32_LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_d = (bus.in_data == sum_q) ? S_DONE : S_ERROR;
`endif
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered and decoded from the next state so they line up with state_q.
    in_ready_d  = (state_d == S_LEN) || (state_d == S_DATA);
    busy_d      = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_FLUSH);
`ifdef NANORV32_LOADER_CHECKSUM_EN
    in_ready_d  = in_ready_d || (state_d == S_CHK);
    busy_d      = busy_d || (state_d == S_CHK);
`endif
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      lane_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef NANORV32_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      lane_q      <= lane_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef NANORV32_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
endmodule

// File: tb/tb_nanorv32_prog_loader.sv
// Randomized bench for nanorv32_prog_loader: images with random byte gaps checked against a word-packing model.
module tb_nanorv32_prog_loader;
  localparam int AW   = 6;
  localparam int BASE = 0;
  localparam int CAP  = 4 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rst_n, busy, done, error;

  nanorv32_prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  nanorv32_prog_loader #(.ADDR_WIDTH(AW), .BASE_WORD(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc = 0, last_we = -1, rise = -1;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic [7:0]    acc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: records RAM writes, accepted bytes and the first cycle the CPU is released.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      wa.delete(); wd.delete(); acc.delete();
      last_we <= -1;
      rise    <= -1;
    end else begin
      if (bus.mem_we) begin
        wa.push_back(bus.mem_addr);
        wd.push_back(bus.mem_wdata);
        last_we <= cyc;
      end
      if (bus.in_valid && bus.in_ready) acc.push_back(bus.in_data);
      if (cpu_rst_n && rise < 0) rise <= cyc;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 32'(BASE));
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_flags",     {29'd0, busy, done, error}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("len_ready", {30'd0, bus.in_ready, busy}, 32'd3);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap = $urandom_range(0, 2);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input string nm, input logic [31:0] len, input logic [7:0] pay[$], input bit bad_sum);
    logic [7:0]  sent[$];
    logic [7:0]  sum;
    logic [31:0] w;
    bit          exp_err;
    int          exp_n, nw, bad;
    do_reset();
    exp_err = (len > 32'(CAP));
    for (int i = 0; i < 4; i++) sent.push_back(len[8*i +: 8]);
    if (!exp_err) begin
      sum = 8'd0;
      foreach (pay[i]) begin
        sent.push_back(pay[i]);
        sum = sum + pay[i];
      end
`ifdef NANORV32_LOADER_CHECKSUM_EN
      sent.push_back(bad_sum ? sum + 8'd1 : sum);
      exp_err = bad_sum;
`endif
    end
    foreach (sent[i]) send_byte(sent[i]);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done || error) break;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_done"},      32'(done), 32'(!exp_err));
    chk({nm, "_error"},     32'(error), 32'(exp_err));
    chk({nm, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(!exp_err));
    chk({nm, "_idle_out"},  {30'd0, bus.in_ready, busy}, 32'd0);
    exp_n = (len > 32'(CAP)) ? 0 : int'((len + 32'd3) / 32'd4);
    chk({nm, "_n_we"}, 32'(wa.size()), 32'(exp_n));
    nw = (wa.size() < exp_n) ? wa.size() : exp_n;
    for (int j = 0; j < nw; j++) begin
      w = 32'd0;
      for (int i = 0; i < 4; i++)
        if (4*j + i < int'(len)) w = w | (32'(pay[4*j + i]) << (8*i));
      chk($sformatf("%s_addr%0d", nm, j), 32'(wa[j]), 32'((BASE + j) % (1 << AW)));
      chk($sformatf("%s_data%0d", nm, j), wd[j], w);
    end
    if (!exp_err && exp_n > 0)
      chk({nm, "_rst_lag"}, 32'(rise > last_we && last_we >= 0), 32'd1);
    bad = (acc.size() == sent.size()) ? 0 : 1;
    foreach (acc[i]) if (i < sent.size() && acc[i] !== sent[i]) bad++;
    chk({nm, "_accepted"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] p[$];
    logic [31:0] rl;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    p = '{8'h13, 8'h12, 8'h11, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load("len8", 32'd8, p, 1'b0);
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    load("len5", 32'd5, p, 1'b0);
    p.delete();
    load("len0", 32'd0, p, 1'b0);
    load("over", 32'(CAP + 1), p, 1'b0);
    for (int i = 0; i < CAP; i++) p.push_back(8'($urandom));
    load("cap", 32'(CAP), p, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rl = 32'($urandom_range(1, 40));
      p.delete();
      for (int i = 0; i < int'(rl); i++) p.push_back(8'($urandom));
      load($sformatf("rnd%0d", r), rl, p, 1'b0);
    end

    // Abort a load partway through DATA; the next load starts with a fresh reset.
    do_reset();
    send_byte(8'd12); send_byte(8'd0); send_byte(8'd0); send_byte(8'd0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    chk("mid_accepted", 32'(acc.size()), 32'd9);
    p.delete();
    for (int i = 0; i < 12; i++) p.push_back(8'($urandom));
    load("after_rst", 32'd12, p, 1'b0);

`ifdef NANORV32_LOADER_CHECKSUM_EN
    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    load("sum_ok", 32'd4, p, 1'b0);
    load("sum_bad", 32'd4, p, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
